wb_mem_monitor: RTL

WB_MEM_MONITOR -- requirements
Module: wb_mem_monitor

---
 rtl/wb_mem_pkg.sv | 21 ++
 rtl/wb_mem_ram.sv | 36 +++
 rtl/wb_mem_monitor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and default constants for the Wibone memory monitor.
// Holds the bus FSM state encoding plus the CALCULATE and firmware-exit defaults.
package wb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

  localparam logic [31:0] MATCH_CALC_DEF = 32'h0000_2027;
  localparam logic [31:0] MASK_CALC_DEF  = 32'hfe00_707f;
  localparam logic [29:0] EXIT_ADR_DEF   = 30'h0400_0001;
  localparam logic [31:0] EXIT_DAT_DEF   = 32'h0000_00ad;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wb_mem_ram.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
// The array is the only storage in the monitor; only the read register is reset.
module wb_mem_ram #(
  parameter int ADDR_W = 17
) (
  input  logic              clk_n,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: the array is deliberately left out of reset; a reset branch over every
  // word would stop it mapping onto block RAM and would wipe firmware contents.
  always_ff @(posedge clk_n) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_n) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_mem_monitor.sv
// Wishbone-attached simulation RAM that also watches for the firmware exit write,
// a cycle budget, and the first estimator CALCULATE instruction on the PCPI port.
module wb_mem_monitor
  import wb_mem_pkg::*;
#(
  parameter int          ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [29:0] EXIT_ADR       = EXIT_ADR_DEF,
  parameter logic [31:0] EXIT_DAT       = EXIT_DAT_DEF,
  parameter logic [31:0] MATCH_CALC     = MATCH_CALC_DEF,
  parameter logic [31:0] MASK_CALC      = MASK_CALC_DEF
) (
  input  logic        clk_n,
  input  logic        reset,
  input  logic [29:0] adr,
  input  logic [31:0] dat,
  input  logic [3:0]  sel,
  input  logic        we,
  input  logic        cyc,
  output logic [31:0] rdt,
  output logic        ack,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  output logic        done,
  output logic        timeout,
  output logic        calc_started,
  output logic [31:0] cycles_total,
  output logic [31:0] calc_cycles
);

  bus_state_e  state;
  logic        commit;
  logic        in_range;
  logic        oor_q;
  logic [31:0] ram_rdata;

  logic [31:0] cnt;
  logic [31:0] cnt_next;
  logic [31:0] start_cycle;
  logic        running;
  logic        exit_hit;
  logic        calc_hit;
  logic        done_set;
  logic        timeout_set;

  // The transfer is sampled on the WAIT->ACK edge; reset on that edge cancels it.
  assign commit   = (state == ST_WAIT) && cyc && !reset;
  assign in_range = (adr >> ADDR_W) == '0;

  wb_mem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_n (clk_n),
    .reset (reset),
    .en    (commit && in_range),
    .we    (we),
    .be    (sel),
    .addr  (adr[ADDR_W-1:0]),
    .wdata (dat),
    .rdata (ram_rdata)
  );

  // Out-of-range reads leave the RAM idle and force the returned word to zero.
  assign rdt = oor_q ? 32'h0 : ram_rdata;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register regardless of block order.
  always_ff @(posedge clk_n) begin
    if (reset) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      ack <= (state == ST_ACK);
      if (commit && !we) oor_q <= !in_range;
      case (state)
        ST_IDLE: if (cyc) state <= ST_WAIT;
        ST_WAIT: state <= cyc ? ST_ACK : ST_IDLE;
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign exit_hit = commit && we && (adr == EXIT_ADR) && (dat == EXIT_DAT);
  assign calc_hit = pcpi_valid && ((pcpi_insn & MASK_CALC) == MATCH_CALC);

  // NOTE: every always_comb output gets a default before any condition, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    running     = !done && !timeout;
    cnt_next    = cnt;
    done_set    = 1'b0;
    timeout_set = 1'b0;
    if (running) begin
      cnt_next    = sat_inc(cnt);
      done_set    = exit_hit;
      timeout_set = !exit_hit && (({1'b0, cnt} + 33'd1) >= 33'(TIMEOUT_CYCLES));
    end
  end

  // cycles_total and the start cycle both record the counter value after the edge.
  always_ff @(posedge clk_n) begin
    if (reset) begin
      cnt          <= '0;
      start_cycle  <= '0;
      calc_started <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycles_total <= '0;
      calc_cycles  <= '0;
    end else begin
      cnt <= cnt_next;
      if (calc_hit && !calc_started) begin
        calc_started <= 1'b1;
        start_cycle  <= cnt_next;
      end
      if (done_set) begin
        done         <= 1'b1;
        cycles_total <= cnt_next;
        calc_cycles  <= calc_started ? (cnt_next - start_cycle) : 32'h0;
      end else if (timeout_set) begin
        timeout      <= 1'b1;
        cycles_total <= cnt_next;
      end
    end
  end

endmodule
